seven_segment_controller: RTL and testbench

- Drives a 4-digit, common-anode, multiplexed seven-segment display.
- Shows a signed 8-bit two's-complement value in decimal: a sign digit plus three magnitude digits.
- Sits between core logic, which supplies `binary`, and the board display pins.
- Time-multiplexes the four digits with a free-running refresh counter.

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seven_segment_decoder.sv | 34 +++
 rtl/seven_segment_controller.sv | 98 +++++++++
 tb/tb_seven_segment_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg : segment patterns, digit codes and index type for the display
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seven_seg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] digit_code_t;

  // Active-low patterns, bit 6 = segment a ... bit 0 = segment g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam digit_code_t CODE_MINUS = 4'hA;
  localparam digit_code_t CODE_BLANK = 4'hF;

endpackage

`default_nettype wire

// File: rtl/seven_segment_decoder.sv
// ---------------------------------------------------------------------------
// seven_segment_decoder : 4-bit digit code to active-low a..g segments
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_segment_decoder
  import seven_seg_pkg::*;
(
  input  digit_code_t code,
  output logic [6:0]  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_controller.sv
// ---------------------------------------------------------------------------
// seven_segment_controller : signed 8-bit value on a 4-digit multiplexed display
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_segment_controller
  import seven_seg_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] binary,
  output logic       anode0_en,
  output logic       anode1_en,
  output logic       anode2_en,
  output logic       anode3_en,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       d_out,
  output logic       e_out,
  output logic       f_out,
  output logic       g_out
);

  logic [SCAN_BITS+1:0] scan_cnt;
  logic [7:0]           bin_q;
  logic [3:0]           anode_q;
  logic [6:0]           seg_q;

  digit_idx_t  sel;
  logic [7:0]  mag;
  logic [6:0]  rem;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;
  digit_code_t code;
  logic [3:0]  anode_d;
  logic [6:0]  seg_d;

  assign sel = scan_cnt[SCAN_BITS+1:SCAN_BITS];

  // 8-bit negate of -128 wraps to 8'h80, which read unsigned is exactly 128
  always_comb begin
    mag  = bin_q[7] ? 8'(~bin_q + 8'd1) : bin_q;
    hund = 4'd0;
    rem  = mag[6:0];
    if (mag >= 8'd100) begin
      hund = 4'd1;
      rem  = 7'(mag - 8'd100);
    end
    tens = 4'(rem / 7'd10);
    ones = 4'(rem % 7'd10);
  end

  always_comb begin
    code = CODE_BLANK;
    case (sel)
      2'd0: code = ones;
      2'd1: code = (hund == 4'd0 && tens == 4'd0) ? CODE_BLANK : tens;
      2'd2: code = (hund == 4'd0) ? CODE_BLANK : hund;
      2'd3: code = bin_q[7] ? CODE_MINUS : CODE_BLANK;
      default: code = CODE_BLANK;
    endcase
    anode_d = ~(4'b0001 << sel);
  end

  seven_segment_decoder u_decoder (
    .code (code),
    .seg  (seg_d)
  );

  // Anode and segments load together so a digit switch never shows stale segments
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      bin_q    <= 8'd0;
      anode_q  <= 4'hF;
      seg_q    <= SEG_BLANK;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      bin_q    <= binary;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign anode0_en = anode_q[0];
  assign anode1_en = anode_q[1];
  assign anode2_en = anode_q[2];
  assign anode3_en = anode_q[3];
  assign {a_out, b_out, c_out, d_out, e_out, f_out, g_out} = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_controller.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_controller : scoreboard bench with a decimal reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seven_segment_controller;

  localparam int SB   = 4;
  localparam int SLOT = 1 << SB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] binary = 8'd0;
  logic       anode0_en, anode1_en, anode2_en, anode3_en;
  logic       a_out, b_out, c_out, d_out, e_out, f_out, g_out;

  logic [3:0] anodes;
  logic [6:0] segs;
  assign anodes = {anode3_en, anode2_en, anode1_en, anode0_en};
  assign segs   = {a_out, b_out, c_out, d_out, e_out, f_out, g_out};

  typedef struct {
    int         digit;
    logic [6:0] seg;
  } exp_t;

  exp_t sb_q[$];
  int   tests  = 0;
  int   errors = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};
  localparam logic [6:0] T_MINUS = 7'b1111110;
  localparam logic [6:0] T_BLANK = 7'b1111111;

  seven_segment_controller #(.SCAN_BITS(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .binary    (binary),
    .anode0_en (anode0_en),
    .anode1_en (anode1_en),
    .anode2_en (anode2_en),
    .anode3_en (anode3_en),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .e_out     (e_out),
    .f_out     (f_out),
    .g_out     (g_out)
  );

  always #5 clk = ~clk;

  // Reference: what a human expects to read on digit d for value v
  function automatic logic [6:0] model_seg(input int v, input int d);
    int m, h, t, o;
    bit neg;
    neg = (v < 0);
    m   = neg ? -v : v;
    h   = m / 100;
    t   = (m / 10) % 10;
    o   = m % 10;
    case (d)
      3:       return neg ? T_MINUS : T_BLANK;
      2:       return (h != 0) ? seg_tab[h] : T_BLANK;
      1:       return (h != 0 || t != 0) ? seg_tab[t] : T_BLANK;
      default: return seg_tab[o];
    endcase
  endfunction

  function automatic int digit_of(input logic [3:0] an);
    for (int i = 0; i < 4; i++)
      if (an[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic push_exp(input int v, input int d);
    exp_t e;
    e.digit = d;
    e.seg   = model_seg(v, d);
    sb_q.push_back(e);
  endtask

  task automatic wait_digit_start(input int d);
    logic [3:0] pat, prev;
    bit ok;
    pat  = 4'(~(4'b0001 << d));
    prev = anodes;
    ok   = 1'b0;
    for (int i = 0; i < 8 * SLOT; i++) begin
      @(negedge clk);
      if (anodes == pat && prev != pat) begin
        ok = 1'b1;
        break;
      end
      prev = anodes;
    end
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_digit%0d: digit never started, anodes=%b", d, anodes);
    end
  endtask

  task automatic wait_queue_empty();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 8 * SLOT) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_value(input int v);
    binary = 8'(v);
    wait_digit_start(3);
    @(negedge clk);
    for (int d = 0; d < 4; d++) push_exp(v, d);
    wait_queue_empty();
  endtask

  // Monitor: each new digit slot is an output presentation
  initial begin
    logic [3:0] prev, cur;
    int last, cyc, idx, pidx;
    bit armed;
    exp_t e;
    prev = 4'hF; last = -1; cyc = 0; armed = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev = 4'hF; last = -1; armed = 1'b0;
        continue;
      end
      cur = anodes;
      if ($onehot(~cur)) armed = 1'b1;
      if (armed) begin
        tests++;
        if (!$onehot(~cur)) begin
          errors++;
          $display("FAIL one_anode_low: anodes=%b, required exactly one 0", cur);
        end
      end
      if (cur != prev && $onehot(~cur)) begin
        idx = digit_of(cur);
        if ($onehot(~prev)) begin
          pidx = digit_of(prev);
          tests++;
          if (idx != (pidx + 1) % 4) begin
            errors++;
            $display("FAIL scan_order: digit %0d after %0d, required %0d", idx, pidx, (pidx + 1) % 4);
          end
          if (last >= 0) begin
            tests++;
            if (cyc - last != SLOT) begin
              errors++;
              $display("FAIL slot_length: %0d cycles, required %0d", cyc - last, SLOT);
            end
          end
        end
        last = cyc;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          tests++;
          if (idx != e.digit || segs != e.seg) begin
            errors++;
            $display("FAIL digit_segs: digit %0d segs %b, required digit %0d segs %b",
                     idx, segs, e.digit, e.seg);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, v2;
    rst    = 1'b0;
    binary = 8'd0;
    repeat (10) @(negedge clk);
    tests++;
    if (anodes !== 4'hF) begin
      errors++;
      $display("FAIL reset_anodes: %b, required 1111", anodes);
    end
    tests++;
    if (segs !== 7'h7F) begin
      errors++;
      $display("FAIL reset_segs: %b, required 1111111", segs);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (anodes !== 4'b1110) begin
      errors++;
      $display("FAIL release_digit0: anodes=%b, required 1110", anodes);
    end

    check_value(-126);
    check_value(38);
    check_value(-128);
    check_value(127);
    check_value(0);
    check_value(-5);
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 255));
      if (v > 127) v -= 256;
      check_value(v);
    end

    // Mid-digit change: the following digits must show the new value
    v  = -93;
    v2 = 45;
    check_value(v);
    wait_digit_start(1);
    repeat (5) @(negedge clk);
    binary = 8'(v2);
    push_exp(v2, 2);
    push_exp(v2, 3);
    push_exp(v2, 0);
    push_exp(v2, 1);
    wait_queue_empty();

    // Asynchronous reset between clock edges during digit 2
    check_value(-107);
    wait_digit_start(2);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (anodes !== 4'hF) begin
      errors++;
      $display("FAIL async_reset_anodes: %b, required 1111", anodes);
    end
    tests++;
    if (segs !== 7'h7F) begin
      errors++;
      $display("FAIL async_reset_segs: %b, required 1111111", segs);
    end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (anodes !== 4'b1110) begin
      errors++;
      $display("FAIL restart_digit0: anodes=%b, required 1110", anodes);
    end
    check_value(-107);
    repeat (3 * 4 * SLOT) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
